uart_tx_io: RTL and testbench

Memory-mapped UART transmitter responding to the c86 CPU byte bus, driving the board `TX` pin (8N1, LSB first). The CPU writes bytes into a 16-entry FIFO, and a bit-timed serializer drains it. Status, overflow flag and baud divisor are visible at four byte offsets. It is instantiated in the board top alongside the RAM/BIOS/video decoders; the top supplies the decoded window select.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_fifo.sv | 47 ++++
 rtl/uart_tx_io.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_io.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// status bit positions and serializer states.
package uart_pkg;

  localparam logic [1:0] UART_DATA = 2'd0;
  localparam logic [1:0] UART_DIVL = 2'd1;
  localparam logic [1:0] UART_DIVH = 2'd2;
  localparam logic [1:0] UART_CLR  = 2'd3;

  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF  = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_t;

  // A programmed divisor of zero behaves as one clock per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with head visible on dout; an extra pointer bit separates full from empty.
// A pop and a push in the same cycle while full both succeed.
module uart_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_reg;
  logic [DEPTH_LOG2:0] rd_ptr_reg;
  logic                do_push;
  logic                do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                   (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_reg[DEPTH_LOG2-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // Storage carries no reset so it can map onto plain distributed RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_io.sv
// CPU-bus UART transmitter: edge-detected register writes, a byte FIFO and an
// 8N1 serializer whose bit period is latched from the divisor at each frame start.
module uart_tx_io
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 115_200,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sel,
  input  logic [1:0] a,
  input  logic [7:0] d,
  input  logic       w,
  output logic [7:0] q,
  output logic       tx
);

  localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / BAUD);

  logic [3:0]  hit;
  logic [3:0]  hit_prev_reg;
  logic [3:0]  fire;
  logic [15:0] div_reg;
  logic        ovf_reg;
  logic        fifo_pop;
  logic        fifo_empty;
  logic        fifo_full;
  logic [7:0]  fifo_dout;
  logic        busy;
  logic [15:0] new_div;
  logic        bit_done;

  uart_state_t state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  idx_reg, idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic [15:0] div_lat_reg, div_lat_next;
  logic        tx_reg, tx_next;

  // One action per contiguous span of a write held on the same offset.
  for (genvar gi = 0; gi < 4; gi++) begin : g_wr
    assign hit[gi] = sel & w & (a == 2'(gi));
  end
  assign fire = hit & ~hit_prev_reg;

  uart_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fire[UART_DATA]),
    .din   (d),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_prev_reg <= '0;
      div_reg      <= DIV_RESET;
      ovf_reg      <= 1'b0;
    end else begin
      hit_prev_reg <= hit;
      if (fire[UART_DIVL]) div_reg[7:0]  <= d;
      if (fire[UART_DIVH]) div_reg[15:8] <= d;
      if (fire[UART_CLR])
        ovf_reg <= 1'b0;
      else if (fire[UART_DATA] & fifo_full & ~fifo_pop)
        ovf_reg <= 1'b1;
    end
  end

  assign new_div  = eff_div(div_reg);
  assign bit_done = (cnt_reg == 16'd0);
  assign busy     = ~fifo_empty | (state_reg != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      shift_reg   <= '0;
      div_lat_reg <= 16'd1;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      shift_reg   <= shift_next;
      div_lat_reg <= div_lat_next;
      tx_reg      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    idx_next     = idx_reg;
    shift_next   = shift_reg;
    div_lat_next = div_lat_reg;
    fifo_pop     = 1'b0;
    tx_next      = 1'b1;
    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          shift_next   = fifo_dout;
          div_lat_next = new_div;
          cnt_next     = new_div - 16'd1;
          state_next   = S_START;
        end
      end
      S_START: begin
        tx_next = 1'b0;
        if (bit_done) begin
          cnt_next   = div_lat_reg - 16'd1;
          idx_next   = 3'd0;
          state_next = S_DATA;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      S_DATA: begin
        tx_next = shift_reg[idx_reg];
        if (bit_done) begin
          cnt_next = div_lat_reg - 16'd1;
          if (idx_reg == 3'd7) state_next = S_STOP;
          else                 idx_next   = idx_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end
      S_STOP: begin
        if (!bit_done) begin
          cnt_next = cnt_reg - 16'd1;
        end else if (!fifo_empty) begin
          // Chain straight into the next frame without an idle cycle.
          fifo_pop     = 1'b1;
          shift_next   = fifo_dout;
          div_lat_next = new_div;
          cnt_next     = new_div - 16'd1;
          state_next   = S_START;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign tx = tx_reg;

  always_comb begin
    q = 8'h00;
    case (a)
      UART_DATA: begin
        q[ST_BUSY] = busy;
        q[ST_FULL] = fifo_full;
        q[ST_OVF]  = ovf_reg;
      end
      UART_DIVL: q = div_reg[7:0];
      UART_DIVH: q = div_reg[15:8];
      default:   q = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_io.sv
// Scoreboard bench for uart_tx_io: stimulus queues expected frames, a tx monitor
// rebuilds each frame cycle by cycle and compares it with the queued byte/period.
module tb_uart_tx_io;

  typedef struct {
    logic [7:0] data;
    int         period;
    bit         contig;
    int         start_cyc;
  } frame_t;

  localparam int FIFO_DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sel = 1'b0;
  logic [1:0] a = 2'd0;
  logic [7:0] d = 8'h00;
  logic       w = 1'b0;
  logic [7:0] q;
  logic       tx;

  uart_tx_io #(
    .CLK_HZ    (25_000_000),
    .BAUD      (115_200),
    .DEPTH_LOG2(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sel   (sel),
    .a     (a),
    .d     (d),
    .w     (w),
    .q     (q),
    .tx    (tx)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  frame_t sb[$];

  // ---------------- monitor ----------------
  frame_t     cur;
  bit         in_frame = 1'b0;
  bit         rogue = 1'b0;
  int         pos = 0;
  int         nerr = 0;
  int         last_end = -100;
  int         frame_no = 0;
  int         mon_bi;
  logic       mon_eb;
  logic [7:0] got;

  always @(negedge clock) begin
    if (reset) begin
      in_frame = 1'b0;
      rogue = 1'b0;
    end else begin
      if (tx === 1'b1) rogue = 1'b0;
      if (!in_frame && tx !== 1'b1 && !rogue) begin
        if (sb.size() == 0) begin
          tests++; fails++; rogue = 1'b1;
          $display("FAIL unexpected_start: tx=%b at cycle %0d with no byte queued, required 1", tx, cyc);
        end else begin
          cur = sb.pop_front();
          in_frame = 1'b1; pos = 0; nerr = 0; got = 8'h00;
          if (cur.contig) begin
            tests++;
            if (cyc != last_end + 1) begin
              fails++;
              $display("FAIL contig_start: start at cycle %0d, required %0d", cyc, last_end + 1);
            end
          end
          if (cur.start_cyc >= 0) begin
            tests++;
            if (cyc != cur.start_cyc) begin
              fails++;
              $display("FAIL start_latency: start at cycle %0d, required %0d", cyc, cur.start_cyc);
            end
          end
        end
      end
      if (in_frame) begin
        mon_bi = pos / cur.period;
        if (mon_bi == 0)      mon_eb = 1'b0;
        else if (mon_bi == 9) mon_eb = 1'b1;
        else                  mon_eb = cur.data[mon_bi-1];
        if (tx !== mon_eb) nerr++;
        if (mon_bi >= 1 && mon_bi <= 8 && (pos % cur.period) == cur.period / 2)
          got[mon_bi-1] = tx;
        pos++;
        if (pos == 10 * cur.period) begin
          in_frame = 1'b0; last_end = cyc; frame_no++; tests++;
          if (nerr != 0) begin
            fails++;
            $display("FAIL frame%0d: got byte %h with %0d wrong tx cycles, required byte %h period %0d",
                     frame_no, got, nerr, cur.data, cur.period);
          end else begin
            $display("[TB] frame%0d byte %h period %0d ends cycle %0d", frame_no, got, cur.period, cyc);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [31:0] gotv, input logic [31:0] expv);
    tests++;
    if (gotv !== expv) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, gotv, expv);
    end else begin
      $display("[TB] %s = %h", name, gotv);
    end
  endtask

  task automatic rd_check(input string name, input logic [1:0] off, input logic [7:0] expv);
    logic [7:0] v;
    a = off; sel = 1'b1; #1; v = q; sel = 1'b0;
    check(name, {24'd0, v}, {24'd0, expv});
    @(negedge clock);
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] val);
    sel = 1'b1; a = off; d = val; w = 1'b1;
    @(negedge clock);
    sel = 1'b0; w = 1'b0;
    @(negedge clock);
  endtask

  task automatic push(input logic [7:0] val, input int period, input bit accept,
                      input bit contig, input bit chk_start);
    if (accept)
      sb.push_back('{data: val, period: period, contig: contig,
                     start_cyc: (chk_start ? cyc + 3 : -1)});
    wr(2'd0, val);
  endtask

  task automatic set_div(input int div);
    wr(2'd1, 8'(div));
    wr(2'd2, 8'(div >> 8));
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while ((sb.size() != 0 || in_frame) && n < limit) begin
      @(negedge clock); n++;
    end
    tests++;
    if (sb.size() != 0 || in_frame) begin
      fails++;
      $display("FAIL %s: %0d frames pending after %0d cycles, required 0", name, sb.size(), n);
      sb.delete();
    end
  endtask

  task automatic idle_check(input string name, input int ncyc);
    int highs = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      if (tx === 1'b1) highs++;
    end
    check(name, highs, ncyc);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] b;
    int n_acc;
    int div, p, n;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check("reset_tx", {31'd0, tx}, 32'd1);
    rd_check("reset_status", 2'd0, 8'h00);
    rd_check("reset_divl", 2'd1, 8'hD9);
    rd_check("reset_divh", 2'd2, 8'h00);
    rd_check("reset_off3", 2'd3, 8'h00);

    // Single frame, divisor 4.
    set_div(4);
    push(8'hA5, 4, 1'b1, 1'b0, 1'b1);
    rd_check("busy_after_push", 2'd0, 8'h01);
    wait_done("a5_frame", 200);
    rd_check("idle_status_a5", 2'd0, 8'h00);

    // Three back-to-back frames at divisor 2.
    set_div(2);
    push(8'h00, 2, 1'b1, 1'b0, 1'b1);
    push(8'hFF, 2, 1'b1, 1'b1, 1'b0);
    push(8'h55, 2, 1'b1, 1'b1, 1'b0);
    wait_done("b2b_frames", 200);

    // Write strobe held for 5 cycles gives one push.
    sb.push_back('{data: 8'h41, period: 2, contig: 1'b0, start_cyc: -1});
    sel = 1'b1; a = 2'd0; d = 8'h41; w = 1'b1;
    repeat (5) @(negedge clock);
    sel = 1'b0; w = 1'b0;
    @(negedge clock);
    wait_done("held_w", 200);
    idle_check("held_w_no_extra", 60);

    // Divisor change mid-frame only affects the following frame.
    set_div(4);
    push(8'h3C, 4, 1'b1, 1'b0, 1'b1);
    push(8'hC9, 16, 1'b1, 1'b1, 1'b0);
    repeat (6) @(negedge clock);
    wr(2'd1, 8'h10);
    wait_done("mid_div_change", 400);

    // Overflow: one byte in flight plus a full FIFO, the rest dropped.
    set_div(1000);
    n_acc = 0;
    for (int i = 0; i < 18; i++) begin
      b = 8'($urandom);
      if (i == 0) b = b & 8'hF7;
      push(b, 1000, (n_acc < FIFO_DEPTH + 1), 1'b0, 1'b0);
      if (n_acc < FIFO_DEPTH + 1) n_acc++;
    end
    rd_check("ovf_status", 2'd0, 8'h07);
    rd_check("ovf_divl", 2'd1, 8'hE8);
    rd_check("ovf_divh", 2'd2, 8'h03);
    wr(2'd3, 8'h5A);
    rd_check("ovf_cleared", 2'd0, 8'h03);

    // Asynchronous reset in the middle of data bit 3 of the first frame.
    n = 0;
    while (!(in_frame && pos >= 4500 && pos < 5000) && n < 20000) begin
      @(negedge clock); n++;
    end
    check("reach_bit3", {31'd0, (in_frame && pos >= 4500 && pos < 5000)}, 32'd1);
    check("tx_before_reset", {31'd0, tx}, 32'd0);
    #2 reset = 1'b1;
    #1 check("tx_async_reset", {31'd0, tx}, 32'd1);
    sb.delete();
    @(negedge clock);
    rd_check("rst_status", 2'd0, 8'h00);
    rd_check("rst_divl", 2'd1, 8'hD9);
    rd_check("rst_divh", 2'd2, 8'h00);
    reset = 1'b0;
    @(negedge clock);
    idle_check("post_reset_idle", 300);

    // Randomized rounds; round 0 programs divisor 0.
    for (int r = 0; r < 6; r++) begin
      div = (r == 0) ? 0 : int'($urandom_range(1, 6));
      p = (div == 0) ? 1 : div;
      set_div(div);
      n = int'($urandom_range(1, 16));
      for (int i = 0; i < n; i++) begin
        push(8'($urandom), p, 1'b1, 1'b0, 1'b0);
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      wait_done("random_round", n * 10 * p + 200);
      rd_check("random_status", 2'd0, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
